// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: N masters share one slave port.
// Grant is held for the whole cyc phase; an ack watchdog ends hung accesses.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst_n,

  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,

  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,

  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int SW = DW / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  logic [1:0]             rst_sync_q;
  logic                   rst_n;

  state_e                 state_q;
  logic [IW-1:0]          gidx_q;
  logic [IW-1:0]          last_q;
  logic [NUM_MASTERS-1:0] grant_q;

  logic                   busy;
  logic                   rel;
  logic                   pick_hit;
  logic [IW-1:0]          pick_idx;
  logic [NUM_MASTERS-1:0] pick_oh;

  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   stall;
  logic                   tmo;

  // Asynchronous assert, two-flop synchronised release of the internal reset
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  assign busy = (state_q == S_BUSY);
  assign rel  = busy && !m_cyc_i[gidx_q];

  // Rotating search for the first requester above the last granted master
  always_comb begin
    int j;
    j        = 0;
    pick_hit = 1'b0;
    pick_idx = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      j = (int'(last_q) + i) % NUM_MASTERS;
      if (!pick_hit && m_cyc_i[IW'(j)]) begin
        pick_hit = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  assign pick_oh = NUM_MASTERS'(1) << pick_idx;

  // Grant FSM: idle until a cyc request, then hold until the owner drops cyc
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      grant_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_hit) begin
            state_q <= S_BUSY;
            gidx_q  <= pick_idx;
            last_q  <= pick_idx;
            grant_q <= pick_oh;
          end
        end
        S_BUSY: begin
          if (rel) begin
            if (pick_hit) begin
              gidx_q  <= pick_idx;
              last_q  <= pick_idx;
              grant_q <= pick_oh;
            end else begin
              state_q <= S_IDLE;
              grant_q <= '0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant_o = grant_q;

  assign s_cyc_o = busy & m_cyc_i[gidx_q];
  assign s_stb_o = busy & m_stb_i[gidx_q];
  assign s_we_o  = busy & m_we_i[gidx_q];
  assign s_adr_o = m_adr_i[gidx_q*AW +: AW];
  assign s_dat_o = m_dat_i[gidx_q*DW +: DW];
  assign s_sel_o = m_sel_i[gidx_q*SW +: SW];
  assign s_cti_o = m_cti_i[gidx_q*3 +: 3];
  assign s_bte_o = m_bte_i[gidx_q*2 +: 2];

  assign m_dat_o = s_dat_i;

  assign stall = busy && s_stb_o && !s_ack_i && !s_err_i;
  assign tmo   = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

  // Watchdog next state: count stalled strobes, restart on any termination
  always_comb begin
    cnt_d = '0;
    if ((TIMEOUT != 0) && stall && !tmo && !rel) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Route termination only to the granted master
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    if (busy) begin
      m_ack_o[gidx_q] = s_ack_i;
      m_err_o[gidx_q] = s_err_i | (tmo & ~s_ack_i);
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: two masters, TIMEOUT=4 main DUT
// plus a TIMEOUT=0 copy on the same stimulus.
module tb_wb_rr_arbiter;

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;
  localparam logic [31:0] RD = 32'hDEAD_BEEF;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic [63:0] m_adr_i;
  logic [63:0] m_dat_i;
  logic [7:0]  m_sel_i;
  logic [1:0]  m_we_i;
  logic [1:0]  m_cyc_i;
  logic [1:0]  m_stb_i;
  logic [5:0]  m_cti_i;
  logic [3:0]  m_bte_i;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic        s_err_i;

  logic [31:0] m_dat_o, z_m_dat_o;
  logic [1:0]  m_ack_o, z_m_ack_o;
  logic [1:0]  m_err_o, z_m_err_o;
  logic [31:0] s_adr_o, z_s_adr_o;
  logic [31:0] s_dat_o, z_s_dat_o;
  logic [3:0]  s_sel_o, z_s_sel_o;
  logic        s_we_o, z_s_we_o;
  logic        s_cyc_o, z_s_cyc_o;
  logic        s_stb_o, z_s_stb_o;
  logic [2:0]  s_cti_o, z_s_cti_o;
  logic [1:0]  s_bte_o, z_s_bte_o;
  logic [1:0]  grant_o, z_grant_o;

  int checks = 0;
  int errors = 0;
  int acks;
  int waits;

  always #5 wb_clk = ~wb_clk;

  wb_rr_arbiter #(.NUM_MASTERS(2), .AW(32), .DW(32), .TIMEOUT(4)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o)
  );

  wb_rr_arbiter #(.NUM_MASTERS(2), .AW(32), .DW(32), .TIMEOUT(0)) dut0 (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(z_m_dat_o), .m_ack_o(z_m_ack_o), .m_err_o(z_m_err_o),
    .s_adr_o(z_s_adr_o), .s_dat_o(z_s_dat_o), .s_sel_o(z_s_sel_o),
    .s_we_o(z_s_we_o), .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o),
    .s_cti_o(z_s_cti_o), .s_bte_o(z_s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(z_grant_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic do_single(input int m, input logic [1:0] expg);
    chk("grant", 32'(grant_o), 32'(expg));
    chk("s_adr", s_adr_o, (m == 0) ? A0 : A1);
    s_ack_i = 1'b1;
    s_dat_i = RD ^ 32'(m);
    #1;
    chk("m_ack", 32'(m_ack_o), 32'(expg));
    chk("m_dat", m_dat_o, RD ^ 32'(m));
    tick();
    s_ack_i    = 1'b0;
    m_cyc_i[m] = 1'b0;
    m_stb_i[m] = 1'b0;
    #1;
    chk("hold", 32'(grant_o), 32'(expg));
    chk("s_cyc_drop", 32'(s_cyc_o), 32'd0);
    tick();
    m_cyc_i[m] = 1'b1;
    m_stb_i[m] = 1'b1;
    #1;
  endtask

  initial begin
    wb_rst_n = 1'b0;
    m_adr_i  = {A1, A0};
    m_dat_i  = {32'h1111_1111, 32'h0000_0000};
    m_sel_i  = 8'hFF;
    m_we_i   = 2'b00;
    m_cyc_i  = 2'b00;
    m_stb_i  = 2'b00;
    m_cti_i  = 6'd0;
    m_bte_i  = 4'd0;
    s_dat_i  = 32'd0;
    s_ack_i  = 1'b0;
    s_err_i  = 1'b0;

    tick();
    tick();
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_cyc", 32'(s_cyc_o), 32'd0);
    wb_rst_n = 1'b1;
    tick();
    tick();

    // First contention: both request together, master 0 wins
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    #1;
    chk("idle_grant", 32'(grant_o), 32'd0);
    chk("idle_stb", 32'(s_stb_o), 32'd0);
    tick();

    // Alternating single accesses with zero idle cycles
    do_single(0, 2'b01);
    do_single(1, 2'b10);
    do_single(0, 2'b01);
    do_single(1, 2'b10);
    do_single(0, 2'b01);

    // Master 1 burst while master 0 keeps requesting
    acks = 0;
    for (int b = 0; b < 8; b++) begin
      m_cti_i[5:3]   = (b == 7) ? 3'b111 : 3'b010;
      m_adr_i[63:32] = A1 + 32'(4 * b);
      s_ack_i        = 1'b1;
      #1;
      chk("b_grant", 32'(grant_o), 32'd2);
      chk("b_cti", 32'(s_cti_o), (b == 7) ? 32'd7 : 32'd2);
      chk("b_adr", s_adr_o, A1 + 32'(4 * b));
      if (m_ack_o == 2'b10) acks++;
      tick();
    end
    s_ack_i        = 1'b0;
    m_cyc_i[1]     = 1'b0;
    m_stb_i[1]     = 1'b0;
    m_cti_i[5:3]   = 3'b000;
    m_adr_i[63:32] = A1;
    #1;
    chk("b_acks", 32'(acks), 32'd8);
    chk("b_hold", 32'(grant_o), 32'd2);
    tick();
    chk("b_next", 32'(grant_o), 32'd1);

    // Watchdog: master 0 stalls, error in the 5th strobe cycle
    m_cyc_i[1] = 1'b1;
    m_stb_i[1] = 1'b1;
    #1;
    for (int c = 1; c <= 5; c++) begin
      chk("wd_err", 32'(m_err_o), (c == 5) ? 32'd1 : 32'd0);
      chk("wd_ack", 32'(m_ack_o), 32'd0);
      if (c == 5) chk("wd0_err", 32'(z_m_err_o), 32'd0);
      tick();
    end
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    #1;
    chk("wd_clr", 32'(m_err_o), 32'd0);
    tick();
    chk("wd_pass", 32'(grant_o), 32'd2);

    // Watchdog: ack arrives exactly in the timeout cycle
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) s_ack_i = 1'b1;
      #1;
      chk("wa_err", 32'(m_err_o), 32'd0);
      chk("wa_ack", 32'(m_ack_o), (c == 5) ? 32'd2 : 32'd0);
      tick();
    end
    s_ack_i    = 1'b0;
    m_cyc_i[1] = 1'b0;
    m_stb_i[1] = 1'b0;
    tick();
    chk("to_idle", 32'(grant_o), 32'd0);
    chk("idle_cyc", 32'(s_cyc_o), 32'd0);

    // Slave error passthrough, counter restarts afterwards
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    tick();
    chk("se_grant", 32'(grant_o), 32'd1);
    tick();
    tick();
    s_err_i = 1'b1;
    #1;
    chk("se_err", 32'(m_err_o), 32'd1);
    chk("se_ack", 32'(m_ack_o), 32'd0);
    tick();
    s_err_i = 1'b0;
    #1;
    for (int c = 1; c <= 5; c++) begin
      chk("se_wd", 32'(m_err_o), (c == 5) ? 32'd1 : 32'd0);
      tick();
    end
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    tick();
    tick();
    chk("se_idle", 32'(grant_o), 32'd0);

    // Reset in beat 3 of a master 1 burst
    m_cyc_i[1]   = 1'b1;
    m_stb_i[1]   = 1'b1;
    m_cti_i[5:3] = 3'b010;
    tick();
    s_ack_i = 1'b1;
    tick();
    tick();
    chk("rb_pre", 32'({grant_o, s_stb_o}), 32'd5);
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    wb_rst_n   = 1'b0;
    #1;
    chk("rb_cyc", 32'(s_cyc_o), 32'd0);
    chk("rb_stb", 32'(s_stb_o), 32'd0);
    chk("rb_grant", 32'(grant_o), 32'd0);
    chk("rb_ack", 32'(m_ack_o), 32'd0);
    s_ack_i = 1'b0;
    tick();
    wb_rst_n = 1'b1;
    waits = 0;
    while (grant_o == 2'b00 && waits < 10) begin
      tick();
      waits++;
    end
    chk("rb_wait", 32'(waits < 10), 32'd1);
    chk("rb_first", 32'(grant_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
